// File: rtl/fifo_pkg.sv
// Shared definitions for the flexible FIFO: read-mode encodings and a sizing helper.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Bits needed to index n items; never less than 1 so a single-entry store still has a field.
  function automatic int clog2_depth(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage for fifo_flex: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 16,
  localparam int ADDR_W = clog2_depth(DEPTH_P)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [WIDTH_P-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [WIDTH_P-1:0] rdata_o
);

  logic [WIDTH_P-1:0] mem [DEPTH_P];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO of any depth >= 2 with valid/ready on both sides, selectable
// first-word-fall-through or registered output, occupancy count, flags and flush.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DEPTH_P        = 16,
  parameter int WIDTH_P        = 8,
  parameter int FWFT_P         = 1,
  parameter int ALMOST_FULL_P  = DEPTH_P - 2,
  parameter int ALMOST_EMPTY_P = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [WIDTH_P-1:0]                data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [WIDTH_P-1:0]                data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [clog2_depth(DEPTH_P+1)-1:0] count_o,
  output logic                              almost_full_o,
  output logic                              almost_empty_o
);

  // In registered mode one entry lives in the output register, so storage is one smaller.
  localparam int STOR_DEPTH = (FWFT_P == FIFO_MODE_FWFT) ? DEPTH_P : DEPTH_P - 1;
  localparam int PTR_W      = clog2_depth(STOR_DEPTH);
  localparam int CNT_W      = clog2_depth(DEPTH_P + 1);

  if (DEPTH_P < 2 || ALMOST_FULL_P > DEPTH_P || ALMOST_EMPTY_P >= DEPTH_P) begin : g_bad_params
    $error("fifo_flex: illegal DEPTH_P/ALMOST_FULL_P/ALMOST_EMPTY_P combination");
  end

  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH_P-1:0] ram_rdata;
  logic               wr_en;
  logic               rd_en;
  logic               rd_adv;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STOR_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ready_o        = (count_q < CNT_W'(DEPTH_P));
  assign wr_en          = valid_i && ready_o;
  assign rd_en          = valid_o && ready_i;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= CNT_W'(ALMOST_FULL_P));
  assign almost_empty_o = (count_q <= CNT_W'(ALMOST_EMPTY_P));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_adv) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  fifo_ram #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (STOR_DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en && !flush_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  if (FWFT_P == FIFO_MODE_FWFT) begin : g_fwft
    assign rd_adv  = rd_en;
    assign valid_o = (count_q != '0);
    // Storage is never reset; mask it so data_o stays defined while empty.
    assign data_o  = valid_o ? ram_rdata : '0;
  end else begin : g_reg
    logic               out_valid_q;
    logic [WIDTH_P-1:0] out_data_q;
    logic               stor_nonempty;
    logic               load;

    // count includes the output register, so storage holds count - out_valid entries.
    assign stor_nonempty = (count_q != CNT_W'(out_valid_q));
    assign load          = stor_nonempty && (!out_valid_q || rd_en);
    assign rd_adv        = load;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ram_rdata;
      end else if (rd_en) begin
        out_valid_q <= 1'b0;
      end
    end

    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;
  end

endmodule
